i2c_write_sequencer: RTL and testbench

//   Upstream feeder for the single-byte I2C write master. Buffers {slave addr, data} write

---
 rtl/i2c_write_sequencer_if.sv | 42 ++++
 rtl/i2c_write_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_i2c_write_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_write_sequencer_if.sv
// i2c_write_sequencer_if
//   Request/bus bundle for i2c_write_sequencer.
//   slave  modport : the sequencer itself (consumes requests, drives the write master).
//   master modport : the environment (request producer and the I2C master's busy/error side).
//   Signals:
//     i_Enable, i_Valid, i_Addr[6:0], i_Data[7:0] : request side into the sequencer
//     o_Ready                                      : FIFO not full
//     o_Wr_Start, o_Slave_Addr[6:0], o_Wr_Byte[7:0]: command to the write master
//     i_Busy, i_Error                              : handshake back from the write master
//     o_Done, o_Err_Count[7:0], o_Fifo_Count, o_Idle : status
interface i2c_write_sequencer_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          i_Enable;
    logic          i_Valid;
    logic [6:0]    i_Addr;
    logic [7:0]    i_Data;
    logic          o_Ready;
    logic          o_Wr_Start;
    logic [6:0]    o_Slave_Addr;
    logic [7:0]    o_Wr_Byte;
    logic          i_Busy;
    logic          i_Error;
    logic          o_Done;
    logic [7:0]    o_Err_Count;
    logic [CW-1:0] o_Fifo_Count;
    logic          o_Idle;

    modport slave (
        input  i_Enable, i_Valid, i_Addr, i_Data, i_Busy, i_Error,
        output o_Ready, o_Wr_Start, o_Slave_Addr, o_Wr_Byte, o_Done,
               o_Err_Count, o_Fifo_Count, o_Idle
    );

    modport master (
        output i_Enable, i_Valid, i_Addr, i_Data, i_Busy, i_Error,
        input  o_Ready, o_Wr_Start, o_Slave_Addr, o_Wr_Byte, o_Done,
               o_Err_Count, o_Fifo_Count, o_Idle
    );
endinterface

// File: rtl/i2c_write_sequencer.sv
// i2c_write_sequencer
//   Buffers {slave addr, data} write requests in a FIFO and hands them one at a
//   time to a single-byte I2C write master: one-cycle o_Wr_Start pulse, wait for
//   the master's busy high/low handshake (or time out), then hold the bus idle
//   for GAP_CYCLES before the next request. Failed requests are counted in a
//   saturating 8-bit counter.
//   Ports: i_Clk, i_Rst (async, active-high), bus (i2c_write_sequencer_if.slave).
//   Build option: define I2C_SEQ_RETRY_EN to re-issue a failed request once
//   before reporting it; otherwise every failure is reported immediately.
module i2c_write_sequencer #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 50,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    i2c_write_sequencer_if.slave  bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

`ifdef I2C_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;

    logic [14:0]   mem [DEPTH];

    logic [2:0]    state_q,      state_d;
    logic [AW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0] count_q,      count_d;
    logic [TW-1:0] timer_q,      timer_d;
    logic [6:0]    addr_q,       addr_d;
    logic [7:0]    byte_q,       byte_d;
    logic          start_q,      start_d;
    logic          done_q,       done_d;
    logic [7:0]    err_q,        err_d;
    logic          busy_q,       busy_d;
    logic          retry_pend_q, retry_pend_d;
    logic          retried_q,    retried_d;

    logic ready;
    logic push;
    logic pop;
    logic fall;
    logic finish;
    logic fail;

    assign ready = (count_q != CW'(DEPTH));
    assign push  = bus.i_Valid & ready;
    // A pending retry takes priority over the FIFO head.
    assign pop   = (state_q == S_IDLE) & ~retry_pend_q & bus.i_Enable & (count_q != '0);
    assign fall  = busy_q & ~bus.i_Busy;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        addr_d       = addr_q;
        byte_d       = byte_q;
        err_d        = err_q;
        retry_pend_d = retry_pend_q;
        retried_d    = retried_q;
        start_d      = 1'b0;
        done_d       = 1'b0;
        busy_d       = bus.i_Busy;
        finish       = 1'b0;
        fail         = 1'b0;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (retry_pend_q) begin
                    retry_pend_d = 1'b0;
                    retried_d    = 1'b1;
                    state_d      = S_ISSUE;
                end else if (pop) begin
                    addr_d    = mem[rd_ptr_q][14:8];
                    byte_d    = mem[rd_ptr_q][7:0];
                    retried_d = 1'b0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Pulse is registered, so it appears while in WAIT_BUSY.
                start_d = 1'b1;
                timer_d = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.i_Busy) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    finish = 1'b1;
                    fail   = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (fall) begin
                    finish = 1'b1;
                    fail   = bus.i_Error;
                end
            end
            S_GAP: begin
                if (timer_q == TW'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            state_d = S_GAP;
            timer_d = '0;
            if (RETRY_EN && fail && !retried_q) begin
                retry_pend_d = 1'b1;
            end else begin
                done_d = 1'b1;
                if (fail && (err_q != 8'hFF)) begin
                    err_d = err_q + 8'd1;
                end
            end
        end
    end

    // Storage is not reset: clearing the pointers discards the contents.
    always_ff @(posedge i_Clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {bus.i_Addr, bus.i_Data};
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            timer_q      <= '0;
            addr_q       <= '0;
            byte_q       <= '0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= '0;
            busy_q       <= 1'b0;
            retry_pend_q <= 1'b0;
            retried_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            addr_q       <= addr_d;
            byte_q       <= byte_d;
            start_q      <= start_d;
            done_q       <= done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            retry_pend_q <= retry_pend_d;
            retried_q    <= retried_d;
        end
    end

    assign bus.o_Ready      = ready;
    assign bus.o_Wr_Start   = start_q;
    assign bus.o_Slave_Addr = addr_q;
    assign bus.o_Wr_Byte    = byte_q;
    assign bus.o_Done       = done_q;
    assign bus.o_Err_Count  = err_q;
    assign bus.o_Fifo_Count = count_q;
    assign bus.o_Idle       = (state_q == S_IDLE) & (count_q == '0) & ~retry_pend_q;
endmodule

// File: tb/tb_i2c_write_sequencer.sv
// tb_i2c_write_sequencer
//   Directed scenarios with randomized request contents and busy timing,
//   checked against a queue-based reference of accepted requests plus a
//   behavioural I2C-master model that decides each attempt's outcome.
`timescale 1ns/1ps
module tb_i2c_write_sequencer;
    localparam int DEPTH = 16;
    localparam int GAP   = 50;
    localparam int TO    = 1023;

`ifdef I2C_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    i2c_write_sequencer_if #(.DEPTH(DEPTH)) bus ();

    i2c_write_sequencer #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TO)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state
    logic [14:0] exp_q[$];
    logic [14:0] cur = '0;
    int  exp_dones = 0;
    int  exp_err   = 0;
    bit  prev_fail  = 1'b0;
    bit  prev_retry = 1'b0;

    // Master model controls and observations
    bit  silent      = 1'b0;
    bit  err_next    = 1'b0;
    int  busy_len    = 0;
    bit  busy_active = 1'b0;
    int  n_starts    = 0;
    int  n_dones     = 0;
    int  last_start_cyc = 0;
    int  last_done_cyc  = 0;
    bit  have_done   = 1'b0;
    bit  prev_done   = 1'b0;

    bit  mm_retry, mm_fail, mm_aborted, mm_final;
    int  mm_dly, mm_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [6:0] a, input logic [7:0] d);
        bit exp_rdy;
        exp_rdy = (exp_q.size() < DEPTH);
        bus.i_Valid = 1'b1;
        bus.i_Addr  = a;
        bus.i_Data  = d;
        check("ready_on_push", bus.o_Ready, exp_rdy);
        if (exp_rdy) exp_q.push_back({a, d});
        @(negedge clk);
        bus.i_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        repeat (2) @(negedge clk);
        while (!(bus.o_Idle && !busy_active) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_reached_idle"}, (k < budget), 1);
    endtask

    task automatic check_totals(input string tag);
        check({tag, "_done_count"}, n_dones, exp_dones);
        check({tag, "_err_count"}, bus.o_Err_Count, exp_err);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    // Done monitor
    always @(negedge clk) begin
        if (!rst && bus.o_Done) begin
            check("done_pulse_width", prev_done, 0);
            n_dones++;
            last_done_cyc = cyc;
            have_done = 1'b1;
        end
        prev_done = bus.o_Done;
    end

    // Behavioural write master: answers each start pulse and predicts the outcome.
    initial begin : master_model
        bus.i_Busy  = 1'b0;
        bus.i_Error = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.o_Wr_Start) begin
                n_starts++;
                last_start_cyc = cyc;
                if (have_done) check("gap_after_done", ((cyc - last_done_cyc) >= GAP), 1);
                mm_retry = RETRY_EN && prev_fail && !prev_retry;
                if (!mm_retry) begin
                    check("start_has_entry", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) cur = exp_q.pop_front();
                end
                check("start_addr", bus.o_Slave_Addr, cur[14:8]);
                check("start_data", bus.o_Wr_Byte, cur[7:0]);
                @(negedge clk);
                check("start_pulse_width", bus.o_Wr_Start, 0);
                mm_aborted = 1'b0;
                if (silent) begin
                    mm_fail = 1'b1;
                end else begin
                    mm_dly = $urandom_range(0, 3);
                    repeat (mm_dly) @(negedge clk);
                    busy_active = 1'b1;
                    bus.i_Busy  = 1'b1;
                    mm_len = (busy_len != 0) ? busy_len : $urandom_range(5, 30);
                    for (int k = 0; k < mm_len && !mm_aborted; k++) begin
                        @(negedge clk);
                        if (rst) mm_aborted = 1'b1;
                    end
                    if (!mm_aborted) begin
                        check("addr_stable_busy", bus.o_Slave_Addr, cur[14:8]);
                        check("data_stable_busy", bus.o_Wr_Byte, cur[7:0]);
                        mm_fail     = err_next;
                        bus.i_Error = err_next;
                        err_next    = 1'b0;
                    end
                    bus.i_Busy = 1'b0;
                    mm_final = !(RETRY_EN && mm_fail && !mm_retry);
                    if (!mm_aborted) begin
                        @(negedge clk);
                        check("done_after_fall", bus.o_Done, mm_final);
                    end
                    bus.i_Error = 1'b0;
                    busy_active = 1'b0;
                end
                if (!mm_aborted) begin
                    mm_final = !(RETRY_EN && mm_fail && !mm_retry);
                    if (mm_final) exp_dones++;
                    if (mm_fail && (!RETRY_EN || mm_retry) && exp_err < 255) exp_err++;
                    prev_fail  = mm_fail;
                    prev_retry = mm_retry;
                end
            end
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int s0, d0, k;
        rst          = 1'b1;
        bus.i_Enable = 1'b0;
        bus.i_Valid  = 1'b0;
        bus.i_Addr   = '0;
        bus.i_Data   = '0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_ready",  bus.o_Ready, 1);
        check("rst_idle",   bus.o_Idle, 1);
        check("rst_start",  bus.o_Wr_Start, 0);
        check("rst_done",   bus.o_Done, 0);
        check("rst_err",    bus.o_Err_Count, 0);
        check("rst_count",  bus.o_Fifo_Count, 0);
        check("rst_addr",   bus.o_Slave_Addr, 0);
        check("rst_byte",   bus.o_Wr_Byte, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", bus.o_Idle, 1);

        // Three directed requests, 20-cycle busy
        bus.i_Enable = 1'b1;
        busy_len = 20;
        s0 = n_starts;
        push(7'h3C, 8'hA5);
        push(7'h3C, 8'h5A);
        push(7'h50, 8'h01);
        wait_idle("three", 2000);
        check("three_starts", n_starts - s0, 3);
        check_totals("three");
        check("three_addr_held", bus.o_Slave_Addr, 7'h50);
        check("three_byte_held", bus.o_Wr_Byte, 8'h01);

        // Random requests with random busy timing
        busy_len = 0;
        s0 = n_starts;
        k = $urandom_range(3, 6);
        for (int i = 0; i < k; i++) push(7'($urandom), 8'($urandom));
        wait_idle("rand", 4000);
        check("rand_starts", n_starts - s0, k);
        check_totals("rand");

        // Fill past DEPTH while disabled
        bus.i_Enable = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push(7'($urandom), 8'($urandom));
        check("full_count", bus.o_Fifo_Count, DEPTH);
        check("full_ready", bus.o_Ready, 0);
        check("full_not_idle", bus.o_Idle, 0);
        repeat (10) @(negedge clk);
        check("disabled_no_start_count", bus.o_Fifo_Count, DEPTH);
        s0 = n_starts;
        bus.i_Enable = 1'b1;
        wait_idle("full_drain", 6000);
        check("full_drain_starts", n_starts - s0, DEPTH);
        check_totals("full_drain");

        // Busy never rises
        silent = 1'b1;
        s0 = n_starts;
        push(7'($urandom), 8'($urandom));
        wait_idle("timeout", 5000);
        check("timeout_starts", n_starts - s0, RETRY_EN ? 2 : 1);
        check("timeout_latency", last_done_cyc - last_start_cyc, TO + 1);
        check_totals("timeout");
        silent = 1'b0;

        // Error on first completion only
        err_next = 1'b1;
        s0 = n_starts;
        d0 = n_dones;
        push(7'($urandom), 8'($urandom));
        wait_idle("err_once", 3000);
        check("err_once_starts", n_starts - s0, RETRY_EN ? 2 : 1);
        check("err_once_one_done", n_dones - d0, 1);
        check_totals("err_once");

        // Simultaneous push and pop at DEPTH-1
        bus.i_Enable = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) push(7'($urandom), 8'($urandom));
        check("pp_pre_count", bus.o_Fifo_Count, DEPTH - 1);
        s0 = n_starts;
        bus.i_Enable = 1'b1;
        push(7'($urandom), 8'($urandom));
        check("pp_count_kept", bus.o_Fifo_Count, DEPTH - 1);
        wait_idle("pp_drain", 6000);
        check("pp_starts", n_starts - s0, DEPTH);
        check_totals("pp_drain");

        // Reset during WAIT_DONE with four requests queued
        busy_len = 200;
        for (int i = 0; i < 5; i++) push(7'($urandom), 8'($urandom));
        k = 0;
        while (!bus.i_Busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rst_test_busy_seen", (k < 200), 1);
        repeat (3) @(negedge clk);
        check("rst_test_queued", bus.o_Fifo_Count, 4);
        rst = 1'b1;
        #1;
        check("midrst_start", bus.o_Wr_Start, 0);
        check("midrst_count", bus.o_Fifo_Count, 0);
        check("midrst_ready", bus.o_Ready, 1);
        check("midrst_idle",  bus.o_Idle, 1);
        check("midrst_done",  bus.o_Done, 0);
        check("midrst_err",   bus.o_Err_Count, 0);
        check("midrst_addr",  bus.o_Slave_Addr, 0);
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        prev_fail  = 1'b0;
        prev_retry = 1'b0;
        exp_err    = 0;
        busy_len   = 0;
        rst = 1'b0;
        s0 = n_starts;
        d0 = n_dones;
        repeat (300) @(negedge clk);
        check("postrst_no_start", n_starts - s0, 0);
        check("postrst_no_done",  n_dones - d0, 0);
        check("postrst_count",    bus.o_Fifo_Count, 0);
        check("postrst_idle",     bus.o_Idle, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
